uart_tx: RTL and testbench
==========================

# uart_tx

Serial 8N1 UART transmitter that sits directly downstream of the debug unit. It takes the byte and level request the debug unit presents, shifts the byte onto the serial line (LSB first) at the configured baud rate, and returns a single-cycle completion pulse. The debug unit uses that pulse to advance to the next byte of the PC word.

## Interface
- DATA_BITS, 8, payload bits per frame
- SB_TICK, 16, oversample ticks in the stop bit (16 = 1 stop bit)
- CLK_FREQ, 50_000_000, i_clk frequency in Hz
- BAUD_RATE, 19200, line rate in baud
- i_clk  in  1  clock
- i_reset  in  1  reset i_reset, asynchronous, active-high; clock i_clk
- i_tx_start  in  1  level request; sampled only in IDLE
- i_tx_data  in  DATA_BITS  byte to send; captured with the request
- o_tx  out  1  serial line, idle high, registered
- o_tx_done  out  1  one-cycle pulse, frame finished
- o_tx_busy  out  1  high whenever state != IDLE

## Operation
- Oversampling is 16 ticks per bit.
- DIV = CLK_FREQ/(BAUD_RATE*16), truncated; DIV must be ≥1.
- One tick occurs every DIV clocks from a local divider counter.
- The divider counter is cleared on every IDLE->START transition, so bit timing is exact: one bit = 16*DIV clocks.
- FSM states and transitions:
  - IDLE: o_tx=1. When i_tx_start=1, capture i_tx_data into the shift register, clear the tick and bit counters, and go to START.
  - START: o_tx=0 for 16 ticks, then go to DATA.
  - DATA: o_tx=shift[0]. Every 16 ticks, shift right and increment the bit counter. After DATA_BITS bits, go to STOP.
  - STOP: o_tx=1 for SB_TICK ticks, then go to DONE.
  - DONE: o_tx=1 and o_tx_done=1 for exactly one cycle, then go to IDLE unconditionally.
- i_tx_start outside IDLE is ignored; there is no queueing.
- i_tx_data changes after capture have no effect on the frame in flight.
- Counter widths:
  - Tick counter: 4 bits minimum, wide enough for max(16, SB_TICK).
  - Bit counter: $clog2(DATA_BITS+1).
  - Divider: $clog2(DIV).
- Illegal state encoding -> IDLE, with outputs at their reset values.

## Timing
- Reset values, applied asynchronously: o_tx=1, o_tx_done=0, o_tx_busy=0, state IDLE, all counters 0.
- Capture at clock edge E0. In the cycle after E0: o_tx=0 and o_tx_busy=1.
- o_tx is low for exactly 16*DIV cycles. Each data bit lasts 16*DIV cycles. The stop bit lasts SB_TICK*DIV cycles.
- o_tx_done is high in cycle (16*(1+DATA_BITS)+SB_TICK)*DIV + 1 after E0, for one cycle.
- o_tx_busy stays high through that cycle and is low in the following cycle.
- Handshake with the debug unit, which holds the request high until it sees done and drops it at the edge ending the done cycle:
  - The block is back in IDLE one cycle after done, when the request is already low.
  - Exactly one frame is sent per request.
- If i_tx_start is held high continuously, the next capture happens on the first IDLE cycle. The line then idles high for 2 cycles between frames: the DONE cycle plus the capture cycle.
- Reset mid-frame: o_tx returns to 1 immediately. No done pulse is issued for the aborted frame. The next request sends a complete new frame.

## Structure
- Shared definitions go in package/header `uart_defs`:
  - state encodings: IDLE, START, DATA, STOP, DONE
  - OVERSAMPLE=16
  - DIV computation
- These are reused by the future uart_rx.
- Sub-module `baud_rate_gen`:
  - inputs: i_clk, i_reset, synchronous i_clear
  - output: o_tick, one cycle every DIV clocks
  - parameter: DIV
- The transmitter FSM and shift register stay in uart_tx.

## Test plan
Bench parameters: CLK_FREQ=1_600_000, BAUD_RATE=10_000, DIV=10, so one bit = 160 clocks and one frame = 1600 clocks.
- Reset applied -> o_tx=1, o_tx_done=0, o_tx_busy=0; releasing reset with start=0 keeps the line high for 1000 cycles.
- Start with 0xA5 -> line sampled mid-bit reads 0,1,0,1,0,0,1,0,1,1; done high for exactly one cycle, 1601 cycles after capture.
- Debug-style handshake sending 0x00,0x00,0x00,0x40 (PC=0x40), request dropped the cycle after each done -> exactly 4 frames, 4 done pulses, correct bytes, no duplicate frame.
- Request pulsed again mid-frame with data changed to 0xFF -> current 0xA5 frame is unaltered and no second frame follows.
- Reset asserted during data bit 3 -> o_tx=1 the same cycle and no done; a following request with 0x3C sends a clean full frame.
- i_tx_start held high with constant 0x55 -> back-to-back frames separated by exactly 2 high cycles; busy low for exactly 1 cycle between frames.

Source files
------------

// File: rtl/uart_defs.sv
// -----------------------------------------------------------------------------
// uart_defs
//   Definitions shared by the UART transmitter and the future receiver:
//   FSM state encodings, the oversampling factor and the baud divider math.
//   No ports (package).
// -----------------------------------------------------------------------------
package uart_defs;

  // Ticks per bit period on the serial line.
  localparam int OVERSAMPLE = 16;

  // Frame sequencer states. Encodings 5..7 are illegal and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } uart_state_e;

  // Clocks per oversample tick, truncated. Callers must keep the result >= 1.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

  // Counter width able to hold 0..n-1; never narrower than one bit so a
  // divide-by-one divider still has a legal vector.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_rate_gen.sv
// -----------------------------------------------------------------------------
// baud_rate_gen
//   Free-running divider producing one oversample tick every DIV clocks.
//   A synchronous clear restarts the count so the first tick after a clear
//   lands exactly DIV clocks later.
//
//   i_clk    in   clock
//   i_reset  in   asynchronous, active-high reset
//   i_clear  in   synchronous restart of the divider
//   o_tick   out  high for one cycle every DIV clocks
// -----------------------------------------------------------------------------
module baud_rate_gen
  import uart_defs::*;
#(
  parameter int DIV = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state is updated with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (i_clear || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign o_tick = (count == LAST);

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   8N1 serial transmitter fed by the debug unit. A level request in IDLE
//   captures the byte, which is shifted out LSB first between a low start
//   bit and a high stop bit. A one-cycle done pulse closes each frame; the
//   requester is expected to drop its request on that pulse.
//
//   i_clk       in   clock
//   i_reset     in   asynchronous, active-high reset
//   i_tx_start  in   level request, only looked at in IDLE
//   i_tx_data   in   byte to send, captured together with the request
//   o_tx        out  serial line, idle high, registered
//   o_tx_done   out  one-cycle pulse when the frame has finished
//   o_tx_busy   out  high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module uart_tx
  import uart_defs::*;
#(
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16,
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 19200
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_start,
  input  logic [DATA_BITS-1:0] i_tx_data,
  output logic                 o_tx,
  output logic                 o_tx_done,
  output logic                 o_tx_busy
);

  localparam int DIV      = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int TICK_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int TW       = ($clog2(TICK_MAX) > 4) ? $clog2(TICK_MAX) : 4;
  localparam int BW       = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_d;
  logic                 capture;
  logic                 tick;

  // Divider restarts on capture so every bit is exactly 16*DIV clocks long.
  baud_rate_gen #(
    .DIV (DIV)
  ) u_baud (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (capture),
    .o_tick  (tick)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    capture = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          state_d = START;
          shift_d = i_tx_data;
          tick_d  = '0;
          bit_d   = '0;
          capture = 1'b1;
        end
      end

      START: begin
        if (tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_q == BIT_LAST) begin
            tick_d  = '0;
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == DATA_LAST) begin
              state_d = STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_q == STOP_LAST) begin
            tick_d  = '0;
            state_d = DONE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
        shift_d = '0;
      end
    endcase

    // Outputs are decoded from the next state and registered, so the line
    // changes on the same edge the state does and never glitches.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // NOTE: the shift register is reset along with the control state; it is a
  // handful of flops, and a defined value keeps the line decode X-free.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
      o_tx_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      o_tx      <= tx_d;
      o_tx_done <= (state_d == DONE);
      o_tx_busy <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Scoreboard bench for uart_tx at DIV=10 (one bit = 160 clocks). The
//   stimulus pushes each byte it expects on the line; a monitor decodes the
//   serial line at mid-bit, times the done pulse and pops/compares.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int DIV        = 10;
  localparam int BIT_CYC    = 16 * DIV;
  localparam int DONE_CYC   = (16 * (1 + 8) + 16) * DIV + 1; // 1601 after capture
  localparam int DONE_LIMIT = 4000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data;
  logic       tx;
  logic       done;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int frames_seen = 0;
  int done_seen   = 0;

  uart_tx #(
    .DATA_BITS (8),
    .SB_TICK   (16),
    .CLK_FREQ  (1_600_000),
    .BAUD_RATE (10_000)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_tx_start (start),
    .i_tx_data  (data),
    .o_tx       (tx),
    .o_tx_done  (done),
    .o_tx_busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  // p counts cycles since capture: p=1 is the first low start-bit cycle.
  bit         mon_active = 1'b0;
  int         mon_p      = 0;
  logic [9:0] mon_line;
  bit         mon_busy_bad;

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_active = 1'b0;
      end else begin
        if (done) done_seen++;
        if (!mon_active) begin
          if (done) check("stray_done", done, 1'b0);
          if (tx == 1'b0) begin
            mon_active   = 1'b1;
            mon_p        = 1;
            mon_line     = '0;
            mon_busy_bad = 1'b0;
          end
        end else begin
          mon_p++;
        end

        if (mon_active) begin
          if (!busy) mon_busy_bad = 1'b1;
          if ((mon_p % BIT_CYC) == BIT_CYC / 2 && (mon_p / BIT_CYC) < 10)
            mon_line[mon_p / BIT_CYC] = tx;
          if (done) begin
            check("done_timing", mon_p, DONE_CYC);
            frames_seen++;
            if (exp_q.size() == 0) begin
              check("unexpected_frame", exp_q.size(), 1);
            end else begin
              e = exp_q.pop_front();
              check("frame_bits", mon_line, {1'b1, e, 1'b0});
            end
            check("busy_in_frame", mon_busy_bad, 1'b0);
            mon_active = 1'b0;
          end else if (mon_p >= DONE_CYC) begin
            check("done_missing", done, 1'b1);
            mon_active = 1'b0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < DONE_LIMIT; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_done_timeout", done, 1'b1);
  endtask

  // Debug-unit handshake: hold the request until done, drop it on the edge
  // that ends the done cycle.
  task automatic send_hs(input logic [7:0] b);
    bit ok;
    start = 1'b1;
    data  = b;
    exp_q.push_back(b);
    wait_done(ok);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int  base_f, base_d, hi, bl;
    bit  ok;
    logic [7:0] pc_bytes [4];

    pc_bytes = '{8'h00, 8'h00, 8'h00, 8'h40};

    rst   = 1'b1;
    start = 1'b0;
    data  = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Line stays idle with no request.
    hi = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx && !busy && !done) hi++;
    end
    check("idle_high_cycles", hi, 1000);

    // Single frame 0xA5: line 0,1,0,1,0,0,1,0,1,1 and done at 1601.
    cycles(1);
    base_f = frames_seen;
    send_hs(8'hA5);
    settle(20);
    check("a5_frames", frames_seen - base_f, 1);

    // Debug-style PC word 0x00000040, four bytes.
    base_f = frames_seen;
    base_d = done_seen;
    for (int i = 0; i < 4; i++) begin
      send_hs(pc_bytes[i]);
      cycles(3);
    end
    settle(1700);
    check("pc_frames", frames_seen - base_f, 4);
    check("pc_done_pulses", done_seen - base_d, 4);
    check("pc_queue_empty", exp_q.size(), 0);

    // Re-request mid-frame with new data: ignored.
    base_f = frames_seen;
    start = 1'b1;
    data  = 8'hA5;
    exp_q.push_back(8'hA5);
    cycles(1);
    start = 1'b0;
    data  = 8'hFF;
    cycles(700);
    start = 1'b1;
    cycles(5);
    start = 1'b0;
    wait_done(ok);
    settle(1700);
    check("midreq_frames", frames_seen - base_f, 1);
    check("midreq_queue_empty", exp_q.size(), 0);

    // Reset during data bit 3 of 0x96 (bit 3 is 0, so the line is low).
    cycles(1);
    base_f = frames_seen;
    base_d = done_seen;
    start = 1'b1;
    data  = 8'h96;
    cycles(1);
    start = 1'b0;
    repeat (720) @(posedge clk);
    #2;
    check("pre_reset_tx_low", tx, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("abort_tx_high", tx, 1'b1);
    check("abort_busy_low", busy, 1'b0);
    check("abort_done_low", done, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    settle(1700);
    check("abort_no_done", done_seen - base_d, 0);
    check("abort_no_frame", frames_seen - base_f, 0);
    cycles(1);
    base_f = frames_seen;
    send_hs(8'h3C);
    settle(20);
    check("after_abort_frames", frames_seen - base_f, 1);

    // Request held high with 0x55: two back-to-back frames.
    cycles(1);
    base_f = frames_seen;
    start = 1'b1;
    data  = 8'h55;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h55);
    wait_done(ok);
    hi = 0;
    bl = 0;
    for (int i = 0; i < 20; i++) begin
      if (!tx) break;
      hi++;
      if (!busy) bl++;
      @(negedge clk);
    end
    check("b2b_gap_high", hi, 2);
    check("b2b_busy_low", bl, 1);
    wait_done(ok);
    @(posedge clk);
    #1 start = 1'b0;
    settle(1700);
    check("b2b_frames", frames_seen - base_f, 2);
    check("b2b_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
